// File: rtl/bcp_axil_pkg.sv
// Shared constants, write-FSM state type and sizing helper for the BCP AXI4-Lite register file.
package bcp_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_e;

    // Ceiling log2, used for ADDR_LSB (bytes per word) and the index field width.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcp_axil_wr_ctrl.sv
// Write channel of the BCP AXI4-Lite register file: AW/W latching, write FSM and B response.
// Emits a one-cycle commit strobe with decoded index, data and strobes for the register array.
module bcp_axil_wr_ctrl
    import bcp_axil_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 8,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned NUM_RO   = 4,
    parameter int unsigned IDX_W    = clog2_f(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW/8-1:0]   i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    output logic              o_commit_c,
    output logic [IDX_W-1:0]  o_idx_c,
    output logic [DW-1:0]     o_wdata_c,
    output logic [DW/8-1:0]   o_wstrb_c
);

    localparam int unsigned ADDR_LSB = clog2_f(DW / 8);
    localparam int unsigned RO_BASE  = NUM_REGS - NUM_RO;

    wr_state_e          r_state;
    wr_state_e          w_state_nxt;
    logic [AW-1:0]      r_awaddr;
    logic [DW-1:0]      r_wdata;
    logic [DW/8-1:0]    r_wstrb;
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               w_awready_nxt;
    logic               w_wready_nxt;
    logic               w_bvalid_nxt;
    logic [1:0]         w_bresp_nxt;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_final;
    logic               w_err;
    logic [AW-1:0]      w_addr;
    logic [IDX_W-1:0]   w_idx;

    assign w_aw_hs = i_awvalid & r_awready;
    assign w_w_hs  = i_wvalid & r_wready;

    // The final beat may come straight off the bus, so select live vs latched per field.
    assign w_addr  = w_aw_hs ? i_awaddr : r_awaddr;
    assign w_idx   = w_addr[ADDR_LSB +: IDX_W];
    assign w_err   = (|(w_addr >> (ADDR_LSB + IDX_W))) | (32'(w_idx) >= RO_BASE);
    assign w_final = (r_state != W_RESP) && (w_state_nxt == W_RESP);

    assign o_commit_c = w_final & ~w_err;
    assign o_idx_c    = w_idx;
    assign o_wdata_c  = w_w_hs ? i_wdata : r_wdata;
    assign o_wstrb_c  = w_w_hs ? i_wstrb : r_wstrb;

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (w_aw_hs) r_awaddr <= i_awaddr;
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
        end
    end

    // State and registered channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_state   <= w_state_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_state_nxt = W_RESP;
                else if (w_aw_hs)      w_state_nxt = W_HAVE_AW;
                else if (w_w_hs)       w_state_nxt = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs)     w_state_nxt = W_RESP;
            W_HAVE_W:  if (w_aw_hs)    w_state_nxt = W_RESP;
            W_RESP:    if (i_bready)   w_state_nxt = W_IDLE;
            default:                   w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = 1'b0;
        w_bresp_nxt   = r_bresp;
        case (w_state_nxt)
            W_IDLE: begin
                w_awready_nxt = 1'b1;
                w_wready_nxt  = 1'b1;
            end
            W_HAVE_AW: w_wready_nxt  = 1'b1;
            W_HAVE_W:  w_awready_nxt = 1'b1;
            W_RESP:    w_bvalid_nxt  = 1'b1;
            default:   w_bvalid_nxt  = 1'b0;
        endcase
        if (w_final) w_bresp_nxt = w_err ? RESP_SLVERR : RESP_OKAY;
    end

endmodule

// File: rtl/bcp_axil_regfile.sv
// Parametrised AXI4-Lite register file for the BCP accelerator: RW array, RO status slots, read path, pulses.
// Optional build macro BCP_AXIL_STICKY_STATUS_EN turns RO slots into read-to-clear sticky latches.
module bcp_axil_regfile
    import bcp_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS           = 16,
    parameter int unsigned NUM_RO             = 4,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]   reg_in,
    output logic [NUM_REGS-1:0]                 wr_pulse,
    output logic [NUM_REGS-1:0]                 rd_pulse
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned ADDR_LSB = clog2_f(SW);
    localparam int unsigned IDX_W    = clog2_f(NUM_REGS);
    localparam int unsigned RO_BASE  = NUM_REGS - NUM_RO;

    logic               w_wr_commit;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [DW-1:0]      w_wr_data;
    logic [SW-1:0]      w_wr_strb;
    logic [DW-1:0]      w_reg_val [NUM_REGS];
    logic               w_ar_hs;
    logic [IDX_W-1:0]   w_ar_idx;
    logic               w_ar_oor;
    logic               r_arready;
    logic               r_rvalid;
    logic [DW-1:0]      r_rdata;
    logic [1:0]         r_rresp;
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic [NUM_REGS-1:0] r_rd_pulse;
    logic               w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    bcp_axil_wr_ctrl #(
        .DW       (DW),
        .AW       (C_S_AXI_ADDR_WIDTH),
        .NUM_REGS (NUM_REGS),
        .NUM_RO   (NUM_RO),
        .IDX_W    (IDX_W)
    ) u_wr_ctrl (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .i_awaddr   (S_AXI_AWADDR),
        .i_awvalid  (S_AXI_AWVALID),
        .o_awready  (S_AXI_AWREADY),
        .i_wdata    (S_AXI_WDATA),
        .i_wstrb    (S_AXI_WSTRB),
        .i_wvalid   (S_AXI_WVALID),
        .o_wready   (S_AXI_WREADY),
        .o_bresp    (S_AXI_BRESP),
        .o_bvalid   (S_AXI_BVALID),
        .i_bready   (S_AXI_BREADY),
        .o_commit_c (w_wr_commit),
        .o_idx_c    (w_wr_idx),
        .o_wdata_c  (w_wr_data),
        .o_wstrb_c  (w_wr_strb)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g < RO_BASE) begin : g_rw
            logic [DW-1:0] r_q;
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    r_q <= '0;
                end else if (w_wr_commit && (w_wr_idx == IDX_W'(g))) begin
                    for (int unsigned b = 0; b < SW; b++) begin
                        if (w_wr_strb[b]) r_q[8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
            end
            assign w_reg_val[g]          = r_q;
            assign reg_out[g*DW +: DW]   = r_q;
        end else begin : g_ro
`ifdef BCP_AXIL_STICKY_STATUS_EN
            // Accumulate status bits; the cycle after a read reloads from the live input so new bits survive.
            logic [DW-1:0] r_q;
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) r_q <= '0;
                else if (r_rd_pulse[g]) r_q <= reg_in[(g-RO_BASE)*DW +: DW];
                else r_q <= r_q | reg_in[(g-RO_BASE)*DW +: DW];
            end
            assign w_reg_val[g] = r_q;
`else
            assign w_reg_val[g] = reg_in[(g-RO_BASE)*DW +: DW];
`endif
            assign reg_out[g*DW +: DW] = '0;
        end
    end

    assign w_ar_hs  = S_AXI_ARVALID & r_arready;
    assign w_ar_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign w_ar_oor = |(S_AXI_ARADDR >> (ADDR_LSB + IDX_W));

    // Read path: data is captured at AR handshake, so a same-cycle write commit is not observed.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (w_ar_hs) begin
                r_rvalid  <= 1'b1;
                r_arready <= 1'b0;
                if (w_ar_oor) begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end else begin
                    r_rdata              <= w_reg_val[w_ar_idx];
                    r_rresp              <= RESP_OKAY;
                    r_rd_pulse[w_ar_idx] <= 1'b1;
                end
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end else if (!r_rvalid) begin
                r_arready <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_wr_commit) r_wr_pulse[w_wr_idx] <= 1'b1;
        end
    end

    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign wr_pulse      = r_wr_pulse;
    assign rd_pulse      = r_rd_pulse;

endmodule
